// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master issues start with operands; the slave reports busy/done and held results.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] difference;
  logic             borrow_out;
  logic             zero;

  modport master (
    output start, a, b,
    input  busy, done, difference, borrow_out, zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, difference, borrow_out, zero
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor step per clock with a registered borrow.
// Results (difference, borrow_out, zero) are held from completion until the next completion.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [WIDTH-1:0]   a_sh_r;
  logic [WIDTH-1:0]   b_sh_r;
  logic [WIDTH-1:0]   res_r;
  logic [WIDTH-1:0]   res_next_s;
  logic               brw_r;
  logic               brw_next_s;
  logic               d_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               last_s;
  logic               load_s;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   difference_r;
  logic               borrow_out_r;
  logic               zero_r;

  // Full-subtractor bit step and the shifted result word it produces.
  always_comb begin
    d_s        = a_sh_r[0] ^ b_sh_r[0] ^ brw_r;
    brw_next_s = (~a_sh_r[0] & b_sh_r[0]) | (~(a_sh_r[0] ^ b_sh_r[0]) & brw_r);
    res_next_s = res_r >> 1;
    res_next_s[WIDTH-1] = d_s;
    last_s     = (cnt_r == CNT_W'(WIDTH - 1));
  end

  // Next-state decode; a new operation is accepted from IDLE or straight out of DONE.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_next_s = SHIFT;
          load_s       = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      SHIFT: begin
        if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = SHIFT;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_next_s = SHIFT;
          load_s       = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
        load_s       = 1'b0;
      end
    endcase
  end

  // State, status flags, datapath shift registers and held results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      a_sh_r       <= '0;
      b_sh_r       <= '0;
      res_r        <= '0;
      brw_r        <= 1'b0;
      cnt_r        <= '0;
      difference_r <= '0;
      borrow_out_r <= 1'b0;
      zero_r       <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == SHIFT);
      done_r  <= (state_next_s == DONE);
      if (load_s) begin
        a_sh_r <= bus.a;
        b_sh_r <= bus.b;
        res_r  <= '0;
        brw_r  <= 1'b0;
        cnt_r  <= '0;
      end else if (state_r == SHIFT) begin
        a_sh_r <= a_sh_r >> 1;
        b_sh_r <= b_sh_r >> 1;
        res_r  <= res_next_s;
        brw_r  <= brw_next_s;
        cnt_r  <= cnt_r + CNT_W'(1);
        if (last_s) begin
          difference_r <= res_next_s;
          borrow_out_r <= brw_next_s;
          zero_r       <= (res_next_s == '0);
        end
      end
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.difference = difference_r;
  assign bus.borrow_out = borrow_out_r;
  assign bus.zero       = zero_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_mis;
  logic [W-1:0] prev_d;
  logic         prev_b;
  logic         prev_z;

  serial_subtractor_if #(.WIDTH(W)) ifc ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation: start pulse, optional ignored start at edge 'poke', full result check.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input int poke);
    int           ai;
    int           bi;
    int           edges;
    int           bcnt;
    bit           held;
    logic [W-1:0] ed;
    logic         eb;
    logic         ez;
    ai = int'(av);
    bi = int'(bv);
    ed = W'((ai + ((1 << W) - bi)) % (1 << W));
    eb = (ai < bi);
    ez = (ai == bi);
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.a     = av;
    ifc.b     = bv;
    @(negedge clk);
    ifc.start = 1'b0;
    ifc.a     = W'($urandom);
    ifc.b     = W'($urandom);
    edges = 0;
    bcnt  = 0;
    held  = 1'b1;
    while (ifc.done !== 1'b1 && edges < 40) begin
      if (ifc.busy === 1'b1) bcnt++;
      if (ifc.difference !== prev_d || ifc.borrow_out !== prev_b || ifc.zero !== prev_z) held = 1'b0;
      if (edges == poke) begin
        ifc.start = 1'b1;
        ifc.a     = 8'hFF;
        ifc.b     = 8'h00;
      end else begin
        ifc.start = 1'b0;
      end
      @(negedge clk);
      edges++;
    end
    ifc.start = 1'b0;
    check("latency", 32'(edges), 32'(W));
    check("busy_cycles", 32'(bcnt), 32'(W));
    check("held_during_op", 32'(held), 32'd1);
    check("busy_in_done", 32'(ifc.busy), 32'd0);
    check("difference", 32'(ifc.difference), 32'(ed));
    check("borrow_out", 32'(ifc.borrow_out), 32'(eb));
    check("zero", 32'(ifc.zero), 32'(ez));
    @(negedge clk);
    check("done_single", 32'(ifc.done), 32'd0);
    check("difference_hold", 32'(ifc.difference), 32'(ed));
    prev_d = ed;
    prev_b = eb;
    prev_z = ez;
  endtask

  initial begin
    int  cyc;
    int  last;
    int  pulses;
    int  n;
    bit  ok;
    n_cmp = 0;
    n_mis = 0;
    prev_d = '0;
    prev_b = 1'b0;
    prev_z = 1'b0;
    ifc.start = 1'b0;
    ifc.a     = '0;
    ifc.b     = '0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_busy", 32'(ifc.busy), 32'd0);
    check("rst_done", 32'(ifc.done), 32'd0);
    check("rst_difference", 32'(ifc.difference), 32'd0);
    check("rst_borrow", 32'(ifc.borrow_out), 32'd0);
    check("rst_zero", 32'(ifc.zero), 32'd0);

    run_op(8'd200, 8'd45, -1);
    run_op(8'd45, 8'd200, -1);
    run_op(8'h00, 8'h01, -1);
    run_op(8'h5A, 8'h5A, -1);
    run_op(8'h10, 8'h03, 3);

    // Continuous start: a result every W+1 cycles, busy low only in DONE cycles.
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.a     = 8'h80;
    ifc.b     = 8'h7F;
    @(negedge clk);
    cyc = 0;
    last = -1;
    pulses = 0;
    ok = 1'b1;
    repeat (30) begin
      if (ifc.busy === ifc.done) ok = 1'b0;
      if (ifc.done === 1'b1) begin
        pulses++;
        check("b2b_difference", 32'(ifc.difference), 32'h01);
        check("b2b_borrow", 32'(ifc.borrow_out), 32'd0);
        if (last >= 0) check("b2b_interval", 32'(cyc - last), 32'(W + 1));
        last = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    check("b2b_pulses", 32'(pulses), 32'd3);
    check("b2b_busy_vs_done", 32'(ok), 32'd1);
    ifc.start = 1'b0;
    n = 0;
    while (ifc.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("b2b_drain", 32'(ifc.done), 32'd1);
    @(negedge clk);
    prev_d = 8'h01;
    prev_b = 1'b0;
    prev_z = 1'b0;

    // Reset four cycles into an operation aborts it and clears the results.
    ifc.start = 1'b1;
    ifc.a     = 8'h33;
    ifc.b     = 8'h11;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(ifc.busy), 32'd0);
    check("abort_done", 32'(ifc.done), 32'd0);
    check("abort_difference", 32'(ifc.difference), 32'd0);
    check("abort_borrow", 32'(ifc.borrow_out), 32'd0);
    check("abort_zero", 32'(ifc.zero), 32'd0);
    ok = 1'b1;
    repeat (15) begin
      if (ifc.done !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    check("abort_no_done", 32'(ok), 32'd1);
    prev_d = '0;
    prev_b = 1'b0;
    prev_z = 1'b0;
    run_op(8'hC3, 8'h3C, -1);

    for (int i = 0; i < 20; i++) begin
      run_op(W'($urandom), W'($urandom), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
